// File: rtl/tone_combiner_if.sv
// Sample bus for the tone combiner: four tone channels in, one combined sample out.
interface tone_combiner_if;
  logic signed [13:0] ch0;
  logic signed [13:0] ch1;
  logic signed [13:0] ch2;
  logic signed [13:0] ch3;
  logic [3:0]         ch_en;
  logic               in_valid;
  logic [1:0]         shift;
  logic               mute;
  logic signed [13:0] dataOut;
  logic               out_valid;
  logic               sat_flag;
  logic [1:0]         ramp_state;

  modport master (
    output ch0, ch1, ch2, ch3, ch_en, in_valid, shift, mute,
    input  dataOut, out_valid, sat_flag, ramp_state
  );

  modport slave (
    input  ch0, ch1, ch2, ch3, ch_en, in_valid, shift, mute,
    output dataOut, out_valid, sat_flag, ramp_state
  );
endinterface

// File: rtl/tone_combiner.sv
// Four-channel tone mixer: masked adder tree, programmable shift, soft-start/stop
// gain ramp and 14-bit saturation in a 3-stage pipeline.
module tone_combiner #(
  parameter int RAMP_LOG2 = 8
) (
  input logic            clk,
  input logic            rst_n,
  tone_combiner_if.slave bus
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = 16 + GW + 1;
  localparam logic [GW-1:0] G_MAX = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0] G_ONE = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] G_ZERO = '0;
  localparam logic signed [PW-1:0] OUT_MAX = 8191;
  localparam logic signed [PW-1:0] OUT_MIN = -8192;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Returns {clip, value}: value clamped to the 14-bit output range.
  function automatic logic [14:0] sat14(input logic signed [PW-1:0] v);
    logic [14:0] res;
    if (v > OUT_MAX)      res = {1'b1, 14'sd8191};
    else if (v < OUT_MIN) res = {1'b1, -14'sd8192};
    else                  res = {1'b0, v[13:0]};
    return res;
  endfunction

  logic signed [13:0] w_c0, w_c1, w_c2, w_c3;
  logic signed [14:0] w_s01, w_s23;
  logic signed [14:0] r_s01_p1, r_s23_p1;
  logic [1:0]         r_shift_p1;
  logic               r_vld_p1;
  logic signed [15:0] w_sum;
  logic signed [15:0] r_sum_p2;
  logic               r_vld_p2;
  logic signed [PW-1:0] w_sum_x, w_gain_x, w_prod, w_scaled;
  logic [14:0]        w_sat;
  logic [GW-1:0]      r_gain;
  logic [GW-1:0]      w_gain_inc, w_gain_dec;
  state_t             r_state;
  logic signed [13:0] r_data_out;
  logic               r_out_valid;
  logic               r_sat;

  assign w_c0  = bus.ch_en[0] ? bus.ch0 : 14'sd0;
  assign w_c1  = bus.ch_en[1] ? bus.ch1 : 14'sd0;
  assign w_c2  = bus.ch_en[2] ? bus.ch2 : 14'sd0;
  assign w_c3  = bus.ch_en[3] ? bus.ch3 : 14'sd0;
  assign w_s01 = {w_c0[13], w_c0} + {w_c1[13], w_c1};
  assign w_s23 = {w_c2[13], w_c2} + {w_c3[13], w_c3};

  // Stage 1: masked pairwise sums; shift is captured with its sample
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      r_s01_p1   <= w_s01;
      r_s23_p1   <= w_s23;
      r_shift_p1 <= bus.shift;
    end
  end

  assign w_sum = {r_s01_p1[14], r_s01_p1} + {r_s23_p1[14], r_s23_p1};

  // Stage 2: full sum with floor shift
  always_ff @(posedge clk) begin
    if (r_vld_p1) r_sum_p2 <= w_sum >>> r_shift_p1;
  end

  assign w_sum_x  = {{(PW-16){r_sum_p2[15]}}, r_sum_p2};
  assign w_gain_x = {{(PW-GW){1'b0}}, r_gain};
  assign w_prod   = w_sum_x * w_gain_x;
  assign w_scaled = w_prod >>> RAMP_LOG2;
  assign w_sat    = sat14(w_scaled);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= bus.in_valid;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Stage 3: gain, saturation, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= 14'sd0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= r_vld_p2;
      if (r_vld_p2) begin
        r_data_out <= w_sat[13:0];
        r_sat      <= w_sat[14];
      end else begin
        r_sat <= 1'b0;
      end
    end
  end

  assign w_gain_inc = r_gain + G_ONE;
  assign w_gain_dec = r_gain - G_ONE;

  // Ramp advances only after a valid stage-3 sample has consumed the current gain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MUTED;
      r_gain  <= G_ZERO;
    end else if (r_vld_p2) begin
      case (r_state)
        MUTED: begin
          if (!bus.mute) begin
            r_gain  <= G_ONE;
            r_state <= (G_ONE == G_MAX) ? ACTIVE : RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (bus.mute) begin
            r_gain  <= w_gain_dec;
            r_state <= (w_gain_dec == G_ZERO) ? MUTED : RAMP_DOWN;
          end else begin
            r_gain  <= w_gain_inc;
            r_state <= (w_gain_inc == G_MAX) ? ACTIVE : RAMP_UP;
          end
        end
        ACTIVE: begin
          if (bus.mute) begin
            r_gain  <= G_MAX - G_ONE;
            r_state <= (G_MAX == G_ONE) ? MUTED : RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (!bus.mute) begin
            r_gain  <= w_gain_inc;
            r_state <= (w_gain_inc == G_MAX) ? ACTIVE : RAMP_UP;
          end else begin
            r_gain  <= w_gain_dec;
            r_state <= (w_gain_dec == G_ZERO) ? MUTED : RAMP_DOWN;
          end
        end
        default: begin
          r_state <= MUTED;
          r_gain  <= G_ZERO;
        end
      endcase
    end
  end

  assign bus.dataOut    = r_data_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.sat_flag   = r_sat;
  assign bus.ramp_state = r_state;

endmodule

// File: tb/tb_tone_combiner.sv
// Scoreboard bench for tone_combiner: reference model predicts each output sample
// and ramp state; a negedge monitor compares outputs as they emerge.
module tb_tone_combiner;
  localparam int RAMP_LOG2 = 8;
  localparam int G = 1 << RAMP_LOG2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tone_combiner_if bus();
  tone_combiner #(.RAMP_LOG2(RAMP_LOG2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic signed [13:0] exp_d_q[$];
  logic               exp_s_q[$];
  int m_state = 0;
  int m_gain  = 0;
  logic [2:0]         hist;
  logic signed [13:0] last_d;
  logic signed [13:0] mon_d;
  logic               mon_s;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_push(input int a, input int b, input int c, input int d);
    longint s, p;
    logic sat;
    s = 0;
    if (bus.ch_en[0]) s += a;
    if (bus.ch_en[1]) s += b;
    if (bus.ch_en[2]) s += c;
    if (bus.ch_en[3]) s += d;
    s = floor_div(s, longint'(1) << bus.shift);
    p = floor_div(s * m_gain, G);
    sat = 1'b0;
    if (p > 8191)  begin p = 8191;  sat = 1'b1; end
    if (p < -8192) begin p = -8192; sat = 1'b1; end
    exp_d_q.push_back(14'(p));
    exp_s_q.push_back(sat);
    case (m_state)
      0: if (!bus.mute) begin m_gain = 1; m_state = (m_gain == G) ? 2 : 1; end
      1: if (bus.mute) begin m_gain--; m_state = (m_gain == 0) ? 0 : 3; end
         else begin m_gain++; m_state = (m_gain == G) ? 2 : 1; end
      2: if (bus.mute) begin m_gain = G - 1; m_state = 3; end
      default: if (!bus.mute) begin m_gain++; m_state = (m_gain == G) ? 2 : 1; end
               else begin m_gain--; m_state = (m_gain == 0) ? 0 : 3; end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 3'b000;
    else        hist <= {hist[1:0], bus.in_valid};
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_d = 14'sd0;
    end else begin
      checks++;
      if (bus.out_valid !== hist[2]) begin
        errors++;
        $display("FAIL valid_align out_valid=%b expected=%b t=%0t", bus.out_valid, hist[2], $time);
      end
      if (bus.out_valid === 1'b1) begin
        if (exp_d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output dataOut=%0d expected no output t=%0t", bus.dataOut, $time);
        end else begin
          mon_d = exp_d_q.pop_front();
          mon_s = exp_s_q.pop_front();
          checks++;
          if (bus.dataOut !== mon_d) begin
            errors++;
            $display("FAIL data dataOut=%0d expected=%0d t=%0t", bus.dataOut, mon_d, $time);
          end
          checks++;
          if (bus.sat_flag !== mon_s) begin
            errors++;
            $display("FAIL sat_flag got=%b expected=%b t=%0t", bus.sat_flag, mon_s, $time);
          end
        end
        last_d = bus.dataOut;
      end else begin
        checks++;
        if (bus.dataOut !== last_d || bus.sat_flag !== 1'b0) begin
          errors++;
          $display("FAIL idle_hold dataOut=%0d sat=%b expected=%0d sat=0 t=%0t", bus.dataOut, bus.sat_flag, last_d, $time);
        end
      end
    end
  end

  task automatic cycle_in(input int a, input int b, input int c, input int d, input logic v);
    bus.ch0 = 14'(a);
    bus.ch1 = 14'(b);
    bus.ch2 = 14'(c);
    bus.ch3 = 14'(d);
    bus.in_valid = v;
    if (v) model_push(a, b, c, d);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_d_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (exp_d_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d expected=0", tag, exp_d_q.size());
    end
    checks++;
    if (bus.ramp_state !== 2'(m_state)) begin
      errors++;
      $display("FAIL %s_state ramp_state=%0d expected=%0d", tag, bus.ramp_state, m_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ch0 = 14'sd123; bus.ch1 = 14'sd123; bus.ch2 = 14'sd123; bus.ch3 = 14'sd123;
    bus.ch_en = 4'hF; bus.shift = 2'd0; bus.mute = 1'b1; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.dataOut !== 14'sd0 || bus.out_valid !== 1'b0 || bus.sat_flag !== 1'b0 || bus.ramp_state !== 2'd0) begin
        errors++;
        $display("FAIL reset dataOut=%0d out_valid=%b sat=%b state=%0d expected 0/0/0/0",
                 bus.dataOut, bus.out_valid, bus.sat_flag, bus.ramp_state);
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_soft_start();
    bus.mute = 1'b0; bus.ch_en = 4'hF; bus.shift = 2'd0;
    repeat (G + 10) cycle_in(1000, 1000, 1000, 1000, 1'b1);
    drain("soft_start");
  endtask

  task automatic test_saturation();
    cycle_in(8191, 8191, 8191, 8191, 1'b1);
    cycle_in(-8192, -8192, -8192, -8192, 1'b1);
    bus.shift = 2'd2;
    cycle_in(8191, 8191, 8191, 8191, 1'b1);
    bus.shift = 2'd0;
    cycle_in(-8192, 8191, -8192, 8191, 1'b1);
    drain("saturation");
  endtask

  task automatic test_masking();
    bus.ch_en = 4'b0101;
    cycle_in(100, 200, 300, 400, 1'b1);
    bus.ch_en = 4'b0000;
    cycle_in(100, 200, 300, 400, 1'b1);
    bus.ch_en = 4'b1010;
    cycle_in(100, 200, 300, 400, 1'b1);
    bus.ch_en = 4'hF;
    drain("masking");
  endtask

  task automatic test_ramp_reversal();
    bus.mute = 1'b1;
    repeat (G) cycle_in(1000, 1000, 1000, 1000, 1'b1);
    drain("ramp_down_full");
    bus.mute = 1'b0;
    repeat (100) cycle_in(1000, 1000, 1000, 1000, 1'b1);
    drain("ramp_up_100");
    bus.mute = 1'b1;
    cycle_in(1000, 1000, 1000, 1000, 1'b1);
    drain("reverse_down");
    repeat (4) cycle_in(1000, 1000, 1000, 1000, 1'b1);
    drain("keep_down");
    bus.mute = 1'b0;
    repeat (3) cycle_in(1000, 1000, 1000, 1000, 1'b1);
    drain("reverse_up");
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 24; i++) begin
      bus.shift = 2'($urandom_range(3));
      cycle_in(int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
               int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
               (i % 2) == 0);
    end
    bus.shift = 2'd0;
    drain("gapped");
  endtask

  task automatic test_mid_reset();
    cycle_in(1000, 1000, 1000, 1000, 1'b1);
    cycle_in(1000, 1000, 1000, 1000, 1'b1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    exp_d_q.delete();
    exp_s_q.delete();
    m_state = 0;
    m_gain  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mute = 1'b0;
    repeat (3) cycle_in(1000, 1000, 1000, 1000, 1'b1);
    drain("mid_reset");
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_saturation();
    test_masking();
    test_ramp_reversal();
    test_gapped();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
